fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised forwarding + load-use hazard controller for the in-order pipeline.
//  Keeps its own shadow of in-flight destination tags for EX..WB and registers the ID-stage source indices into EX.
//  Drives per-operand forward selects for EX and the ID stall.
//  Supersedes the combinational two-source, two-stage forwarding selector.
// PARAMETERS
//  NUM_SRC   2  source operands per instruction
//  RAW       5  register-index width
//  DEPTH     3  shadow slots: slot0=EX, slot1=MEM, ..., slot DEPTH-1=WB; forward sources = slots 1..DEPTH-1
//  LOAD_LAT  1  load result is forwardable only from slot >= 1+LOAD_LAT; legal 0..DEPTH-2
// PORTS
//  clk           in   1                   clock, rising edge
//  rst_n         in   1                   synchronous reset, active low
//  id_valid      in   1                   valid instruction in ID
//  id_rs         in   NUM_SRC*RAW         ID source indices, src i at [i*RAW +: RAW]
//  id_rs_used    in   NUM_SRC             source i is actually read
//  id_rd         in   RAW                 ID destination index
//  id_reg_write  in   1                   ID instruction writes id_rd
//  id_is_load    in   1                   ID instruction is a load
//  flush         in   1                   branch/jump resolved taken in EX; squash ID
//  ext_hold      in   1                   global freeze (e.g. memory wait)
//  stall_id      out  1                   hold PC and IF/ID, insert bubble into EX
//  fwd_sel       out  NUM_SRC*SELW        SELW=$clog2(DEPTH); 0 = register file, k = slot k result
//  fwd_hit       out  NUM_SRC             fwd_sel[i] != 0
// BEHAVIOUR
//  - Slot = {valid, rd, reg_write, is_load}. Registered state: slots 0..DEPTH-1 plus ex_rs/ex_rs_used.
//  - Reset (rst_n=0 at an edge): all slots invalid, ex_rs_used=0. Hence stall_id=0, fwd_sel=0, fwd_hit=0.
//  - load_use (comb.): id_valid && !flush && some used id_rs[i] != 0 matches a valid, reg_write, is_load slot j with j < LOAD_LAT.
//  - stall_id = load_use | ext_hold. flush overrides load_use, because the ID instruction is dead.
//  - Edge, ext_hold=1: all state holds, whatever flush or load_use are.
//  - Edge, ext_hold=0:
//      slot[k] <= slot[k-1] for k >= 1.
//      slot0 <= ID info if id_valid && !load_use && !flush; otherwise a bubble (valid=0).
//      ex_rs / ex_rs_used load under the same condition; otherwise ex_rs_used <= 0.
//  - fwd_sel[i] (comb. from registered state): lowest k in 1..DEPTH-1 with all of:
//      ex_rs_used[i]; slot[k].valid; slot[k].reg_write; slot[k].rd == ex_rs[i]; ex_rs[i] != 0;
//      (!slot[k].is_load || k >= 1+LOAD_LAT).
//    No match -> 0.
//  - Priority: youngest producer wins. Index 0 never forwards and never stalls.
//  - A source with id_rs_used=0 never stalls.
//  - Latency: fwd_sel is valid in the same cycle the instruction occupies EX. stall_id acts in the same cycle.
//  - With LOAD_LAT=L, a dependent load-use pair costs exactly L bubbles.
//  - A flush arriving together with load_use: no stall; the bubble comes from the flush.
//  - rst_n low mid-stall: the stall releases at the next edge.
// CONFIGURATION
//  - HAZARD_STATS_EN defined:
//      adds output stall_cycles [31:0]. It counts edges where load_use=1 and ext_hold=0 and saturates at 32'hFFFF_FFFF.
//      Reset value 0.
//  - Not defined: port and counter absent. All other behaviour is identical.
// STRUCTURE
//  - Package hazard_pkg:
//      slot_t struct; SELW localparam function; FWD_RF=0 constant.
//  - Sub-module fwd_src_select:
//      one operand's priority matcher over the slot vector.
//      NUM_SRC copies via generate.
//  - Slot shift register and load_use stay in the top level.
// TESTING
//  - Reset: hold rst_n=0 for 2 cycles with id_valid=1 -> stall_id=0, fwd_sel=0 on the first cycle after release.
//  - ALU chain: add x5 then sub x6,x5,x5 on consecutive cycles.
//      -> sub in EX shows fwd_sel[0]=fwd_sel[1]=1 (MEM).
//      -> With one unrelated instruction between them, fwd_sel=2.
//  - Load-use: lw x7 then add x8,x7,x1.
//      -> stall_id=1 for exactly 1 cycle.
//      -> add in EX gets fwd_sel[0]=2, fwd_sel[1]=0.
//  - Same instruction, LOAD_LAT=2 and DEPTH=4 -> 2 stall cycles; fwd_sel[0]=3.
//  - Priority and x0:
//      -> add x3; add x3; or x9,x3,x0 -> fwd_sel[0]=1, fwd_sel[1]=0.
//      -> Writes to x0 never forward.
//  - Flush and hold:
//      -> lw x7 then add x8,x7 with flush=1 in the same cycle -> stall_id=0; the next EX slot is a bubble.
//      -> ext_hold=1 for 3 cycles freezes fwd_sel; stall_cycles (HAZARD_STATS_EN) does not change.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the forwarding / load-use hazard unit.
// Slot rd fields are MAX_RAW wide; narrower register indices are zero-extended.
`default_nettype none

package hazard_pkg;

  localparam int MAX_RAW = 8;
  localparam int FWD_RF  = 0;

  typedef struct packed {
    logic               valid;
    logic [MAX_RAW-1:0] rd;
    logic               reg_write;
    logic               is_load;
  } slot_t;

  function automatic int sel_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_src_select.sv
// Forward-select priority matcher for one EX source operand.
// Scans slots 1..DEPTH-1 and picks the youngest eligible producer.
`default_nettype none

module fwd_src_select
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int RAW      = 5,
  parameter int SELW     = 2
) (
  input  slot_t [DEPTH-1:1] slots_i,
  input  logic  [RAW-1:0]   rs_i,
  input  logic              rs_used_i,
  output logic  [SELW-1:0]  sel_o,
  output logic              hit_o
);

  logic [MAX_RAW-1:0] rs_ext;
  assign rs_ext = MAX_RAW'(rs_i);

  // Walk from oldest to youngest so the youngest match is the one that sticks.
  always_comb begin
    sel_o = SELW'(FWD_RF);
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (rs_used_i && (rs_i != '0) &&
          slots_i[k].valid && slots_i[k].reg_write &&
          (slots_i[k].rd == rs_ext) &&
          (!slots_i[k].is_load || (k >= 1 + LOAD_LAT))) begin
        sel_o = SELW'(k);
      end
    end
  end

  assign hit_o = (sel_o != SELW'(FWD_RF));

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// Forwarding + load-use hazard controller with a shadow of in-flight EX..WB destinations.
// Optional HAZARD_STATS_EN adds a saturating count of load-use stall edges.
`default_nettype none

module fwd_hazard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int RAW      = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  localparam int SELW    = sel_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid_i,
  input  logic [NUM_SRC*RAW-1:0]   id_rs_i,
  input  logic [NUM_SRC-1:0]       id_rs_used_i,
  input  logic [RAW-1:0]           id_rd_i,
  input  logic                     id_reg_write_i,
  input  logic                     id_is_load_i,
  input  logic                     flush_i,
  input  logic                     ext_hold_i,
`ifdef HAZARD_STATS_EN
  output logic [31:0]              stall_cycles_o,
`endif
  output logic                     stall_id_o,
  output logic [NUM_SRC*SELW-1:0]  fwd_sel_o,
  output logic [NUM_SRC-1:0]       fwd_hit_o
);

  slot_t [DEPTH-1:0]      slots_q, slots_d;
  logic [NUM_SRC*RAW-1:0] ex_rs_q, ex_rs_d;
  logic [NUM_SRC-1:0]     ex_rs_used_q, ex_rs_used_d;
  logic                   load_use;
  logic                   accept;

  // Only slots younger than LOAD_LAT can hold a load whose data is not ready yet.
  always_comb begin
    load_use = 1'b0;
    if (id_valid_i && !flush_i) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        for (int j = 0; j < LOAD_LAT; j++) begin
          if (id_rs_used_i[i] && (id_rs_i[i*RAW +: RAW] != '0) &&
              slots_q[j].valid && slots_q[j].reg_write && slots_q[j].is_load &&
              (slots_q[j].rd == MAX_RAW'(id_rs_i[i*RAW +: RAW]))) begin
            load_use = 1'b1;
          end
        end
      end
    end
  end

  assign accept     = id_valid_i && !load_use && !flush_i;
  assign stall_id_o = load_use | ext_hold_i;

  always_comb begin
    slots_d      = slots_q;
    ex_rs_d      = ex_rs_q;
    ex_rs_used_d = ex_rs_used_q;
    if (!ext_hold_i) begin
      for (int k = 1; k < DEPTH; k++) begin
        slots_d[k] = slots_q[k-1];
      end
      if (accept) begin
        slots_d[0].valid     = 1'b1;
        slots_d[0].rd        = MAX_RAW'(id_rd_i);
        slots_d[0].reg_write = id_reg_write_i;
        slots_d[0].is_load   = id_is_load_i;
        ex_rs_d              = id_rs_i;
        ex_rs_used_d         = id_rs_used_i;
      end else begin
        slots_d[0]   = '0;
        ex_rs_used_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slots_q      <= '0;
      ex_rs_q      <= '0;
      ex_rs_used_q <= '0;
    end else begin
      slots_q      <= slots_d;
      ex_rs_q      <= ex_rs_d;
      ex_rs_used_q <= ex_rs_used_d;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_select #(
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .RAW      (RAW),
      .SELW     (SELW)
    ) u_sel (
      .slots_i   (slots_q[DEPTH-1:1]),
      .rs_i      (ex_rs_q[i*RAW +: RAW]),
      .rs_used_i (ex_rs_used_q[i]),
      .sel_o     (fwd_sel_o[i*SELW +: SELW]),
      .hit_o     (fwd_hit_o[i])
    );
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else if (load_use && !ext_hold_i && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench: DUT A (DEPTH=3, LOAD_LAT=1) and DUT B (DEPTH=4, LOAD_LAT=2) share stimulus.
`default_nettype none

module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_is_load;
  logic       flush;
  logic       ext_hold;

  logic       stall_a, stall_b;
  logic [3:0] sel_a, sel_b;
  logic [1:0] hit_a, hit_b;
`ifdef HAZARD_STATS_EN
  logic [31:0] cnt_a, cnt_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         dut;
    logic [3:0] sel;
    string      name;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  fwd_hazard_unit #(.NUM_SRC(2), .RAW(5), .DEPTH(3), .LOAD_LAT(1)) u_dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rs_used_i   (id_rs_used),
    .id_rd_i        (id_rd),
    .id_reg_write_i (id_reg_write),
    .id_is_load_i   (id_is_load),
    .flush_i        (flush),
    .ext_hold_i     (ext_hold),
`ifdef HAZARD_STATS_EN
    .stall_cycles_o (cnt_a),
`endif
    .stall_id_o     (stall_a),
    .fwd_sel_o      (sel_a),
    .fwd_hit_o      (hit_a)
  );

  fwd_hazard_unit #(.NUM_SRC(2), .RAW(5), .DEPTH(4), .LOAD_LAT(2)) u_dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rs_used_i   (id_rs_used),
    .id_rd_i        (id_rd),
    .id_reg_write_i (id_reg_write),
    .id_is_load_i   (id_is_load),
    .flush_i        (flush),
    .ext_hold_i     (ext_hold),
`ifdef HAZARD_STATS_EN
    .stall_cycles_o (cnt_b),
`endif
    .stall_id_o     (stall_b),
    .fwd_sel_o      (sel_b),
    .fwd_hit_o      (hit_b)
  );

  // One ID cycle: called at posedge+1, checks stall mid-cycle, then after the
  // edge pops the expected EX forward selects {src1,src0} and compares them.
  task automatic issue(input string name, input int dut,
                       input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic fl, input logic hold,
                       input logic exp_stall, input logic [1:0] e0, input logic [1:0] e1);
    exp_t       e;
    logic       got_stall;
    logic [3:0] got_sel;
    logic [1:0] got_hit;
    logic [1:0] exp_hit;
    id_valid     = v;
    id_rs        = {rs1, rs0};
    id_rs_used   = used;
    id_rd        = rd;
    id_reg_write = rw;
    id_is_load   = ld;
    flush        = fl;
    ext_hold     = hold;
    sbq.push_back('{dut, {e1, e0}, name});
    #5;
    got_stall = (dut == 0) ? stall_a : stall_b;
    n_tests++;
    if (got_stall !== exp_stall) begin
      n_fail++;
      $display("FAIL %s stall_id got %b expected %b", name, got_stall, exp_stall);
    end
    @(posedge clk);
    #1;
    e       = sbq.pop_front();
    got_sel = (e.dut == 0) ? sel_a : sel_b;
    got_hit = (e.dut == 0) ? hit_a : hit_b;
    exp_hit = {|e.sel[3:2], |e.sel[1:0]};
    n_tests++;
    if (got_sel !== e.sel) begin
      n_fail++;
      $display("FAIL %s fwd_sel got %h expected %h", e.name, got_sel, e.sel);
    end
    n_tests++;
    if (got_hit !== exp_hit) begin
      n_fail++;
      $display("FAIL %s fwd_hit got %b expected %b", e.name, got_hit, exp_hit);
    end
  endtask

  task automatic drain(input int dut);
    repeat (4) issue("drain", dut, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    rst_n        = 1'b0;
    id_valid     = 1'b1;
    id_rs        = {5'd5, 5'd5};
    id_rs_used   = 2'b11;
    id_rd        = 5'd5;
    id_reg_write = 1'b1;
    id_is_load   = 1'b1;
    flush        = 1'b0;
    ext_hold     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #5;
    n_tests++;
    if (stall_a !== 1'b0 || stall_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset stall_id got %b/%b expected 0/0", stall_a, stall_b);
    end
    n_tests++;
    if (sel_a !== 4'h0 || sel_b !== 4'h0 || hit_a !== 2'b00) begin
      n_fail++;
      $display("FAIL reset fwd_sel got %h/%h expected 0/0", sel_a, sel_b);
    end
    @(posedge clk);
    #1;
    drain(0);
    // reset asserted while a load-use stall is active
    issue("rst_lw", 0, 1, 5'd2, 0, 2'b01, 5'd7, 1, 1, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    issue("rst_mid", 0, 1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0, 0, 1, 0, 0);
    rst_n = 1'b1;
    issue("rst_rel", 0, 1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0, 0, 0, 0, 0);
    drain(0);
  endtask

  task automatic test_alu_chain;
    issue("alu_add", 0, 1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 0, 0, 0, 0, 0, 0);
    issue("alu_sub", 0, 1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 0, 0, 0, 0, 1, 1);
    drain(0);
    issue("gap_add", 0, 1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 0, 0, 0, 0, 0, 0);
    issue("gap_mid", 0, 1, 5'd1, 5'd2, 2'b11, 5'd10, 1, 0, 0, 0, 0, 0, 0);
    issue("gap_sub", 0, 1, 5'd5, 5'd5, 2'b11, 5'd6, 1, 0, 0, 0, 0, 2, 2);
    drain(0);
  endtask

  task automatic test_load_use;
`ifdef HAZARD_STATS_EN
    logic [31:0] c0;
    c0 = cnt_a;
`endif
    issue("lu_lw", 0, 1, 5'd2, 0, 2'b01, 5'd7, 1, 1, 0, 0, 0, 0, 0);
    issue("lu_add_stall", 0, 1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0, 0, 1, 0, 0);
    issue("lu_add_go", 0, 1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0, 0, 0, 2, 0);
`ifdef HAZARD_STATS_EN
    n_tests++;
    if (cnt_a !== c0 + 32'd1) begin
      n_fail++;
      $display("FAIL lu_stats got %0d expected %0d", cnt_a, c0 + 32'd1);
    end
`endif
    drain(0);
  endtask

  task automatic test_load_lat2;
    drain(1);
    issue("l2_lw", 1, 1, 5'd2, 0, 2'b01, 5'd7, 1, 1, 0, 0, 0, 0, 0);
    issue("l2_stall1", 1, 1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0, 0, 1, 0, 0);
    issue("l2_stall2", 1, 1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0, 0, 1, 0, 0);
    issue("l2_go", 1, 1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 0, 0, 0, 3, 0);
    drain(1);
  endtask

  task automatic test_priority_x0;
    issue("pr_add1", 0, 1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0, 0, 0, 0, 0, 0);
    issue("pr_add2", 0, 1, 5'd1, 5'd2, 2'b11, 5'd3, 1, 0, 0, 0, 0, 0, 0);
    issue("pr_or", 0, 1, 5'd3, 5'd0, 2'b11, 5'd9, 1, 0, 0, 0, 0, 1, 0);
    drain(0);
    issue("x0_wr", 0, 1, 5'd1, 5'd2, 2'b11, 5'd0, 1, 0, 0, 0, 0, 0, 0);
    issue("x0_rd", 0, 1, 5'd0, 5'd0, 2'b11, 5'd4, 1, 0, 0, 0, 0, 0, 0);
    drain(0);
    // unused source never forwards even on a matching tag
    issue("un_add", 0, 1, 5'd1, 5'd2, 2'b11, 5'd12, 1, 0, 0, 0, 0, 0, 0);
    issue("un_rd", 0, 1, 5'd12, 5'd12, 2'b10, 5'd13, 1, 0, 0, 0, 0, 0, 1);
    drain(0);
  endtask

  task automatic test_flush_hold;
`ifdef HAZARD_STATS_EN
    logic [31:0] c0;
`endif
    issue("fl_lw", 0, 1, 5'd2, 0, 2'b01, 5'd7, 1, 1, 0, 0, 0, 0, 0);
    issue("fl_add", 0, 1, 5'd7, 5'd1, 2'b11, 5'd8, 1, 0, 1, 0, 0, 0, 0);
    issue("fl_next", 0, 1, 5'd8, 5'd0, 2'b01, 5'd9, 1, 0, 0, 0, 0, 0, 0);
    drain(0);
    issue("ho_add", 0, 1, 5'd1, 5'd2, 2'b11, 5'd5, 1, 0, 0, 0, 0, 0, 0);
    issue("ho_lw", 0, 1, 5'd5, 0, 2'b01, 5'd7, 1, 1, 0, 0, 0, 1, 0);
`ifdef HAZARD_STATS_EN
    c0 = cnt_a;
`endif
    repeat (3) issue("ho_freeze", 0, 1, 5'd7, 5'd0, 2'b11, 5'd8, 1, 0, 0, 1, 1, 1, 0);
`ifdef HAZARD_STATS_EN
    n_tests++;
    if (cnt_a !== c0) begin
      n_fail++;
      $display("FAIL ho_stats got %0d expected %0d", cnt_a, c0);
    end
`endif
    issue("ho_lu", 0, 1, 5'd7, 5'd0, 2'b11, 5'd8, 1, 0, 0, 0, 1, 0, 0);
    issue("ho_go", 0, 1, 5'd7, 5'd0, 2'b11, 5'd8, 1, 0, 0, 0, 0, 2, 0);
    drain(0);
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_load_lat2();
    test_priority_x0();
    test_flush_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

`default_nettype wire
